// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one 4-way lookahead level per stage,
// top-down carry resolution and sum formation in the last stage, elastic valid/ready flow.
module pipelined_cla_adder #(
    parameter  int LEVELS = 2,
    localparam int WIDTH  = 4**LEVELS,
    localparam int LAT    = LEVELS + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             p_out,
    output logic             g_out
);

    logic             adv;
    logic [LAT-1:0]   vld_q;

    // [stage][level] propagate/generate words; stage s holds levels 0..s
    logic [WIDTH-1:0] lp_q [0:LEVELS][0:LEVELS];
    logic [WIDTH-1:0] lg_q [0:LEVELS][0:LEVELS];
    logic [WIDTH-1:0] lp_d [0:LEVELS][0:LEVELS];
    logic [WIDTH-1:0] lg_d [0:LEVELS][0:LEVELS];
    logic [LEVELS:0]  cin_q, cin_d;

    logic [WIDTH-1:0] car [0:LEVELS];
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             p_out_q, g_out_q;

    function automatic logic [2*WIDTH-1:0] group4(input logic [WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] gp, gg;
        gp = '0;
        gg = '0;
        for (int j = 0; j < WIDTH/4; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        return {gp, gg};
    endfunction

    // Carries into each of four sub-blocks given the carry into the block.
    function automatic logic [3:0] cla4(input logic [3:0] p, input logic [3:0] g,
                                        input logic c);
        logic [3:0] cy;
        cy[0] = c;
        cy[1] = g[0] | (p[0] & c);
        cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        return cy;
    endfunction

    assign adv       = !vld_q[LAT-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LAT-1];
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign p_out     = p_out_q;
    assign g_out     = g_out_q;

    always_comb begin
        for (int s = 0; s <= LEVELS; s++) begin
            for (int l = 0; l <= LEVELS; l++) begin
                lp_d[s][l] = '0;
                lg_d[s][l] = '0;
            end
        end
        cin_d = '0;

        b_eff      = sub ? ~b : b;
        lp_d[0][0] = a ^ b_eff;
        lg_d[0][0] = a & b_eff;
        cin_d[0]   = sub | c_in;

        for (int s = 1; s <= LEVELS; s++) begin
            cin_d[s] = cin_q[s-1];
            for (int l = 0; l < s; l++) begin
                lp_d[s][l] = lp_q[s-1][l];
                lg_d[s][l] = lg_q[s-1][l];
            end
            {lp_d[s][s], lg_d[s][s]} = group4(lp_q[s-1][s-1], lg_q[s-1][s-1]);
        end
    end

    // Final stage: push the carry-in down through every lookahead level to bit carries.
    always_comb begin
        for (int l = 0; l <= LEVELS; l++) car[l] = '0;
        car[LEVELS][0] = cin_q[LEVELS];
        for (int l = LEVELS; l >= 1; l--) begin
            for (int j = 0; j < WIDTH/4; j++) begin
                car[l-1][4*j +: 4] = cla4(lp_q[LEVELS][l-1][4*j +: 4],
                                          lg_q[LEVELS][l-1][4*j +: 4], car[l][j]);
            end
        end
        sum_d   = lp_q[LEVELS][0] ^ car[0];
        c_out_d = lg_q[LEVELS][LEVELS][0] | (lp_q[LEVELS][LEVELS][0] & cin_q[LEVELS]);
        ovf_d   = car[0][WIDTH-1] ^ c_out_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            p_out_q <= 1'b0;
            g_out_q <= 1'b0;
        end else if (adv) begin
            vld_q   <= {vld_q[LAT-2:0], in_valid};
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            p_out_q <= lp_q[LEVELS][LEVELS][0];
            g_out_q <= lg_q[LEVELS][LEVELS][0];
        end
    end

    // Datapath stages carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (adv) begin
            lp_q  <= lp_d;
            lg_q  <= lg_d;
            cin_q <= cin_d;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: LEVELS=1,2,3 instances share one stimulus stream,
// each scoreboarded against an arithmetic model; LEVELS=2 also pinned by literal vectors.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        c_in = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        chk_drain = 1'b0;
    int          tests = 0;
    int          fails = 0;

    logic [63:0] sum_w [3];
    logic        ov_w [3];
    logic        ir_w [3];
    logic        co_w [3];
    logic        ovf_w [3];
    logic        p_w [3];
    logic        g_w [3];

    typedef struct {
        logic [67:0] exp;
        longint      tag;
    } beat_t;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Returns {p_out, g_out, ovf, c_out, sum} for a w-bit adder.
    function automatic logic [67:0] model(input logic [63:0] av, input logic [63:0] bv,
                                          input logic ci, input logic sb, input int w);
        logic [63:0] m, m1, aa, bb;
        logic [64:0] full, nog, low;
        logic        cin_e, co, cm, pp, gg;
        m     = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        m1    = m >> 1;
        aa    = av & m;
        bb    = (sb ? ~bv : bv) & m;
        cin_e = sb | ci;
        full  = {1'b0, aa} + {1'b0, bb} + {64'd0, cin_e};
        nog   = {1'b0, aa} + {1'b0, bb};
        low   = {1'b0, aa & m1} + {1'b0, bb & m1} + {64'd0, cin_e};
        co    = full[w];
        cm    = low[w-1];
        gg    = nog[w];
        pp    = ((aa ^ bb) == m);
        return {pp, gg, cm ^ co, co, full[63:0] & m};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LV = gi + 1;
        localparam int W  = 4**LV;
        localparam int LT = LV + 2;

        logic [W-1:0] s;
        logic         ov, ir, co, of, po, go;
        beat_t        q[$];
        longint       n_adv = 0;
        logic         held = 1'b0;
        logic [67:0]  snap = '0;

        pipelined_cla_adder #(.LEVELS(LV)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (ir),
            .a        (a[W-1:0]),
            .b        (b[W-1:0]),
            .c_in     (c_in),
            .sub      (sub),
            .out_valid(ov),
            .out_ready(out_ready),
            .sum      (s),
            .c_out    (co),
            .ovf      (of),
            .p_out    (po),
            .g_out    (go)
        );

        assign sum_w[gi] = 64'(s);
        assign ov_w[gi]  = ov;
        assign ir_w[gi]  = ir;
        assign co_w[gi]  = co;
        assign ovf_w[gi] = of;
        assign p_w[gi]   = po;
        assign g_w[gi]   = go;

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                held = 1'b0;
            end else begin
                check($sformatf("L%0d in_ready", LV), 64'(ir), 64'(!ov || out_ready));
                if (held) begin
                    check($sformatf("L%0d hold_sum", LV), 64'(s), snap[63:0]);
                    check($sformatf("L%0d hold_flags", LV), 64'({ov, po, go, of, co}),
                          64'({1'b1, snap[67:64]}));
                end
                if (chk_drain)
                    check($sformatf("L%0d drained", LV), 64'(q.size()), 64'd0);
                if (ov) begin
                    check($sformatf("L%0d out_has_beat", LV), 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        check($sformatf("L%0d sum", LV), 64'(s), q[0].exp[63:0]);
                        check($sformatf("L%0d flags", LV), 64'({po, go, of, co}),
                              64'(q[0].exp[67:64]));
                        check($sformatf("L%0d latency", LV), 64'(n_adv - q[0].tag), 64'(LT));
                    end
                end
                if (ov && out_ready && q.size() != 0) void'(q.pop_front());
                if (in_valid && ir) q.push_back('{model(a, b, c_in, sub, W), n_adv});
                if (!ov || out_ready) n_adv++;
                held = ov && !out_ready;
                snap = {po, go, of, co, 64'(s)};
            end
        end
    end

    task automatic directed(input string nm, input logic [63:0] av, input logic [63:0] bv,
                            input logic ci, input logic sb, input logic [15:0] es,
                            input logic eco, input logic eov, input logic ep, input logic eg);
        a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({nm, " early_valid"}, 64'(ov_w[1]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({nm, " valid"}, 64'(ov_w[1]), 64'd1);
        check({nm, " sum"}, sum_w[1], 64'(es));
        check({nm, " co_ovf_p_g"}, 64'({co_w[1], ovf_w[1], p_w[1], g_w[1]}),
              64'({eco, eov, ep, eg}));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk_drain = 1'b1;
        @(negedge clk);
        #1 chk_drain = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int  acc, cyc;
        logic got;

        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset out_valid", 64'(ov_w[k]), 64'd0);
            check("reset sum", sum_w[k], 64'd0);
            check("reset flags", 64'({co_w[k], ovf_w[k], p_w[k], g_w[k]}), 64'd0);
            check("reset in_ready", 64'(ir_w[k]), 64'd1);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_release in_ready", 64'(ir_w[1]), 64'd1);
        @(posedge clk); #1;

        directed("ffff+1", 64'hFFFF, 64'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        directed("7fff+1", 64'h7FFF, 64'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        directed("8000-1", 64'h8000, 64'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
        directed("ripple", 64'h5555, 64'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        directed("5-3 cin", 64'h0005, 64'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1);
        directed("0-1", 64'h0000, 64'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back stream with a three-cycle downstream stall
        acc = 0;
        cyc = 0;
        a = rnd64(); b = rnd64(); c_in = $urandom_range(0, 1) != 0; sub = $urandom_range(0, 1) != 0;
        in_valid = 1'b1;
        while (acc < 8 && cyc < 40) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            @(negedge clk);
            if (!out_ready) begin
                check("stall out_valid", 64'(ov_w[1]), 64'd1);
                check("stall in_ready", 64'(ir_w[1]), 64'd0);
            end
            got = ir_w[1];
            @(posedge clk); #1;
            if (got) begin
                acc++;
                a = rnd64(); b = rnd64();
                c_in = $urandom_range(0, 1) != 0; sub = $urandom_range(0, 1) != 0;
            end
            cyc++;
        end
        check("stall beats accepted", 64'(acc), 64'd8);
        drain();

        // Reset with beats in flight
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = rnd64(); b = rnd64(); c_in = $urandom_range(0, 1) != 0; sub = 1'b0;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        check("pre_reset out_valid", 64'(ov_w[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("async reset out_valid", 64'(ov_w[k]), 64'd0);
            check("async reset sum", sum_w[k], 64'd0);
            check("async reset flags", 64'({co_w[k], ovf_w[k], p_w[k], g_w[k]}), 64'd0);
            check("async reset in_ready", 64'(ir_w[k]), 64'd1);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check("release in_ready", 64'(ir_w[k]), 64'd1);
        @(posedge clk); #1;
        drain();

        // Long mixed add/sub stream with random valid and backpressure
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 8;
            a = rnd64(); b = rnd64();
            c_in = $urandom_range(0, 1) != 0; sub = $urandom_range(0, 1) != 0;
            @(posedge clk); #1;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter LEVELS, default 2, number of 4-bit lookahead levels; legal values 1..3.
REQ-002 SHALL have derived parameter WIDTH = 4**LEVELS (4, 16 or 64), operand width.
REQ-003 SHALL have derived parameter LAT = LEVELS + 2, input-to-output latency in cycles.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 c_in  input  1  carry-in; ignored when sub=1.
REQ-011 sub  input  1  mode select: 0 = A+B+c_in, 1 = A-B.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the result when out_valid && out_ready.
REQ-014 sum  output  WIDTH  result, modulo 2**WIDTH.
REQ-015 c_out  output  1  carry out of bit WIDTH-1.
REQ-016 ovf  output  1  signed two's-complement overflow.
REQ-017 p_out  output  1  whole-word group propagate, for cascading.
REQ-018 g_out  output  1  whole-word group generate, for cascading.

Function
REQ-019 Stage 0 SHALL register the per-bit values p=a^b', g=a&b' and the effective carry-in, where b'=~b and effective carry-in=1 when sub=1, and b'=b and effective carry-in=c_in otherwise.
REQ-020 Stages 1..LEVELS SHALL each register one level of 4-way lookahead: group p = AND of 4 p; group g = g3|p3g2|p3p2g1|p3p2p1g0.
REQ-021 Carries SHALL be resolved top-down with 4-bit lookahead equations, and sum bits SHALL be registered in the final stage LAT-1.
REQ-022 Each stage SHALL carry forward the operand bits it still needs; a beat's own data SHALL NOT be mixed with another beat's data.
REQ-023 c_out SHALL equal g_out | (p_out & effective carry-in).
REQ-024 ovf SHALL equal carry into bit WIDTH-1 XOR c_out.
REQ-025 Pipeline enable SHALL be adv = !out_valid || out_ready; all LAT stages and their valid bits shift together when adv=1, and hold otherwise.
REQ-026 in_ready SHALL equal adv, driven combinationally from out_ready and out_valid with no other input in the path.
REQ-027 When adv=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 0.
REQ-028 Bubbles SHALL NOT be collapsed.
REQ-029 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-030 Results SHALL emerge in acceptance order, exactly LAT enabled cycles after acceptance.
REQ-031 While out_valid=1 and out_ready=0, all outputs SHALL remain stable.
REQ-032 sub and c_in SHALL be sampled per beat, so mixed add/sub streams are legal.

Reset
REQ-033 rst_n=0 SHALL immediately clear all stage valid bits, out_valid, sum, c_out, ovf, p_out and g_out to 0, independent of clk.
REQ-034 Beats in flight during reset SHALL be discarded; none SHALL appear after reset release.
REQ-035 in_ready SHALL be 1 during reset and in the first cycle after release.

Verification
REQ-036 LEVELS=2, a=16'hFFFF, b=16'h0001, c_in=0, sub=0 -> after 4 cycles: sum=16'h0000, c_out=1, ovf=0, p_out=0, g_out=1.
REQ-037 LEVELS=2, a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, c_out=0, ovf=1; then a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, c_out=1, ovf=1.
REQ-038 LEVELS=2, a=16'h5555, b=16'hAAAA, c_in=1 -> sum=16'h0000, c_out=1, p_out=1, g_out=0 (full-width ripple).
REQ-039 Back-to-back stream of 8 random beats with out_ready low in cycles 5..7 -> outputs held during the stall, in_ready=0 while stalled, all 8 results correct and in order, no loss or duplication.
REQ-040 Reset asserted while 3 beats are in flight -> out_valid=0 at once, and no stale result after release.
REQ-041 LEVELS=1 and LEVELS=3 -> 10k random add/sub beats match a reference model, with latency 3 and 5 cycles respectively.
